// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB update path.
//
// Contents:
//   BTB_SETS / BTB_WAYS     - geometry of the branch target buffer
//   IDX_W / TAG_W / CNTR_W  - set index, tag and bimodal counter widths
//   BR_TYPE_JUMP            - branch type code for unconditional jumps
//   upd_kind_e              - kind of queued update (allocate/weaken/reinforce)
//   btb_upd_t               - one queued update record
//   sat_inc / sat_dec       - 2-bit saturating counter helpers
package btb_pkg;

  localparam int unsigned BTB_SETS = 64;
  localparam int unsigned BTB_WAYS = 2;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned TAG_W    = 24;
  localparam int unsigned CNTR_W   = 2;

  localparam logic [1:0] BR_TYPE_COND = 2'b00;
  localparam logic [1:0] BR_TYPE_JUMP = 2'b10;

  typedef enum logic [1:0] {
    UPD_ALLOC     = 2'd0,
    UPD_WEAKEN    = 2'd1,
    UPD_REINFORCE = 2'd2
  } upd_kind_e;

  typedef struct packed {
    upd_kind_e          kind;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [31:0]        target;
    logic [CNTR_W-1:0]  cntr_pred;
    logic [1:0]         br_type;
  } btb_upd_t;

  function automatic logic [CNTR_W-1:0] sat_inc(input logic [CNTR_W-1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'b01;
  endfunction

  function automatic logic [CNTR_W-1:0] sat_dec(input logic [CNTR_W-1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'b01;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small FIFO holding pending BTB update records.
//
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset (empties the queue)
//   push_i        - enqueue data_i; accepted when not full, or when full and
//                   pop_i is also high (the slot freed this cycle is reused)
//   pop_i         - drop the head record (ignored when empty)
//   data_i        - record to enqueue
//   data_o        - head record, valid while empty_o is low
//   full_o        - DEPTH records stored
//   empty_o       - no records stored
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  btb_upd_t data_i,
  output btb_upd_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  btb_upd_t         mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == DEPTH_C);
  assign empty_o = (cnt_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    // DEPTH is a power of two, so the pointers wrap on their own.
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_push && !do_pop) cnt_d = cnt_q + 1'b1;
    if (do_pop && !do_push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/btb_update_unit.sv
// BTB update unit: queues branch-resolution update records and applies them
// to a 2-way, 64-set BTB through a shared read/write port on which fetch has
// priority (btb_port_gnt_i).  Each record is handled by a read of its set,
// a compare cycle, and, when needed, one write.  Only one record is in
// flight, so a set is never read while a write to it is pending.
//
// Ports:
//   cpu_clock_i, cpu_reset_i   - clock, synchronous active-high reset
//   rcu_excp_i                 - mispredict record valid (ALLOC / WEAKEN)
//   c1_btb_bm_mod_i            - correctly predicted taken (REINFORCE)
//   c1_btb_vpc_i, c1_btb_target_i, c1_cntr_pred_i, c1_bnch_tkn_i,
//   c1_bnch_type_i, c1_bnch_present_i - resolved branch information
//   btb_port_gnt_i             - update port granted this cycle
//   btb_rd_en_o / btb_rd_idx_o - set read request
//   btb_rd_vld_i / btb_rd_tag_i / btb_rd_cntr_i - per-way read data, valid
//                                the cycle after a granted read
//   btb_wr_*_o                 - entry write request and payload
//   perf_upd_cnt_o / perf_drop_cnt_o - records written / dropped on full,
//                                present only when BTB_UPD_PERF_EN is defined
module btb_update_unit
  import btb_pkg::*;
#(
  parameter int unsigned UPD_DEPTH = 4
) (
  input  logic        cpu_clock_i,
  input  logic        cpu_reset_i,
  input  logic        rcu_excp_i,
  input  logic [31:0] c1_btb_vpc_i,
  input  logic [31:0] c1_btb_target_i,
  input  logic [1:0]  c1_cntr_pred_i,
  input  logic        c1_bnch_tkn_i,
  input  logic [1:0]  c1_bnch_type_i,
  input  logic        c1_bnch_present_i,
  input  logic        c1_btb_bm_mod_i,
  input  logic        btb_port_gnt_i,
  output logic        btb_rd_en_o,
  output logic [5:0]  btb_rd_idx_o,
  input  logic [1:0]  btb_rd_vld_i,
  input  logic [47:0] btb_rd_tag_i,
  input  logic [3:0]  btb_rd_cntr_i,
  output logic        btb_wr_en_o,
  output logic [5:0]  btb_wr_idx_o,
  output logic        btb_wr_way_o,
  output logic        btb_wr_vld_o,
  output logic [23:0] btb_wr_tag_o,
  output logic [31:0] btb_wr_target_o,
  output logic [1:0]  btb_wr_type_o,
  output logic [1:0]  btb_wr_cntr_o
`ifdef BTB_UPD_PERF_EN
  ,
  output logic [31:0] perf_upd_cnt_o,
  output logic [31:0] perf_drop_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_CMP,
    ST_WR
  } state_e;

  state_e            state_q, state_d;
  btb_upd_t          enq_rec, head;
  upd_kind_e         enq_kind;
  logic              enq_vld, fifo_full, fifo_empty, fifo_pop;

  logic [BTB_SETS-1:0] victim_q, victim_d;

  // Write payload decided in CMP and held through WR.
  logic              wr_way_q, wr_way_d;
  logic              wr_vld_q, wr_vld_d;
  logic [1:0]        wr_cntr_q, wr_cntr_d;
  logic              alloc_miss_q, alloc_miss_d;

  logic              hit0, hit1, hit, hit_way;
  logic [1:0]        hit_cntr;
  logic              need_wr;

  logic              c1_tkn_unused;
  assign c1_tkn_unused = c1_bnch_tkn_i;

  // A mispredict record takes precedence over a reinforce in the same cycle.
  always_comb begin
    enq_vld = rcu_excp_i | c1_btb_bm_mod_i;
    if (rcu_excp_i) enq_kind = c1_bnch_present_i ? UPD_ALLOC : UPD_WEAKEN;
    else            enq_kind = UPD_REINFORCE;
    enq_rec = '{kind:      enq_kind,
                idx:       c1_btb_vpc_i[7:2],
                tag:       c1_btb_vpc_i[31:8],
                target:    c1_btb_target_i,
                cntr_pred: c1_cntr_pred_i,
                br_type:   c1_bnch_type_i};
  end

  btb_upd_fifo #(
    .DEPTH (UPD_DEPTH)
  ) u_fifo (
    .clk_i   (cpu_clock_i),
    .rst_i   (cpu_reset_i),
    .push_i  (enq_vld),
    .pop_i   (fifo_pop),
    .data_i  (enq_rec),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Tag compare on the read data; way 0 wins when both ways hit.
  always_comb begin
    hit0     = btb_rd_vld_i[0] && (btb_rd_tag_i[23:0]  == head.tag);
    hit1     = btb_rd_vld_i[1] && (btb_rd_tag_i[47:24] == head.tag);
    hit      = hit0 | hit1;
    hit_way  = !hit0;
    hit_cntr = hit_way ? btb_rd_cntr_i[3:2] : btb_rd_cntr_i[1:0];
  end

  always_comb begin
    need_wr      = 1'b0;
    wr_way_d     = hit_way;
    wr_vld_d     = 1'b1;
    wr_cntr_d    = '0;
    alloc_miss_d = 1'b0;
    unique case (head.kind)
      UPD_ALLOC: begin
        need_wr      = 1'b1;
        wr_way_d     = hit ? hit_way : victim_q[head.idx];
        alloc_miss_d = !hit;
        if (head.br_type == BR_TYPE_JUMP) wr_cntr_d = 2'b11;
        else if (hit)                     wr_cntr_d = sat_inc(head.cntr_pred);
        else                              wr_cntr_d = 2'b10;
      end
      UPD_WEAKEN: begin
        need_wr   = hit;
        wr_cntr_d = sat_dec(hit_cntr);
        wr_vld_d  = (hit_cntr != 2'b00);
      end
      UPD_REINFORCE: begin
        need_wr   = hit;
        wr_cntr_d = sat_inc(hit_cntr);
      end
      default: need_wr = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    btb_rd_en_o = 1'b0;
    btb_wr_en_o = 1'b0;
    victim_d    = victim_q;
    unique case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_RD;
      ST_RD: begin
        btb_rd_en_o = 1'b1;
        if (btb_port_gnt_i) state_d = ST_CMP;
      end
      ST_CMP: begin
        // Weaken/reinforce of an absent entry retires here without a write.
        if (need_wr) state_d = ST_WR;
        else begin
          fifo_pop = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_WR: begin
        btb_wr_en_o = 1'b1;
        if (btb_port_gnt_i) begin
          fifo_pop = 1'b1;
          state_d  = ST_IDLE;
          if (alloc_miss_q) victim_d[head.idx] = ~victim_q[head.idx];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    btb_rd_idx_o    = '0;
    btb_wr_idx_o    = '0;
    btb_wr_way_o    = 1'b0;
    btb_wr_vld_o    = 1'b0;
    btb_wr_tag_o    = '0;
    btb_wr_target_o = '0;
    btb_wr_type_o   = '0;
    btb_wr_cntr_o   = '0;
    if (state_q == ST_RD) btb_rd_idx_o = head.idx;
    if (state_q == ST_WR) begin
      btb_wr_idx_o    = head.idx;
      btb_wr_way_o    = wr_way_q;
      btb_wr_vld_o    = wr_vld_q;
      btb_wr_tag_o    = head.tag;
      btb_wr_target_o = head.target;
      btb_wr_type_o   = head.br_type;
      btb_wr_cntr_o   = wr_cntr_q;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      state_q      <= ST_IDLE;
      victim_q     <= '0;
      wr_way_q     <= 1'b0;
      wr_vld_q     <= 1'b0;
      wr_cntr_q    <= '0;
      alloc_miss_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (state_q == ST_CMP) begin
        wr_way_q     <= wr_way_d;
        wr_vld_q     <= wr_vld_d;
        wr_cntr_q    <= wr_cntr_d;
        alloc_miss_q <= alloc_miss_d;
      end
    end
  end

`ifdef BTB_UPD_PERF_EN
  logic [31:0] perf_upd_q, perf_drop_q;

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      perf_upd_q  <= '0;
      perf_drop_q <= '0;
    end else begin
      if (btb_wr_en_o && btb_port_gnt_i)        perf_upd_q  <= perf_upd_q + 32'd1;
      if (enq_vld && fifo_full && !fifo_pop)    perf_drop_q <= perf_drop_q + 32'd1;
    end
  end

  assign perf_upd_cnt_o  = perf_upd_q;
  assign perf_drop_cnt_o = perf_drop_q;
`endif

endmodule

// File: tb/tb_btb_update_unit.sv
module tb_btb_update_unit;

  localparam int DEPTH  = 4;
  localparam int K_ALLOC = 0;
  localparam int K_WEAK  = 1;
  localparam int K_REIN  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        excp, bm, present, tkn, gnt;
  logic [31:0] vpc, tgt;
  logic [1:0]  cp, ty;
  logic        rd_en;
  logic [5:0]  rd_idx;
  logic [1:0]  rd_vld;
  logic [47:0] rd_tag;
  logic [3:0]  rd_cntr;
  logic        wr_en, wr_way, wr_vld;
  logic [5:0]  wr_idx;
  logic [23:0] wr_tag;
  logic [31:0] wr_tgt;
  logic [1:0]  wr_ty, wr_cntr;
`ifdef BTB_UPD_PERF_EN
  logic [31:0] perf_upd, perf_drop;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  btb_update_unit #(
    .UPD_DEPTH (DEPTH)
  ) dut (
    .cpu_clock_i       (clk),
    .cpu_reset_i       (rst),
    .rcu_excp_i        (excp),
    .c1_btb_vpc_i      (vpc),
    .c1_btb_target_i   (tgt),
    .c1_cntr_pred_i    (cp),
    .c1_bnch_tkn_i     (tkn),
    .c1_bnch_type_i    (ty),
    .c1_bnch_present_i (present),
    .c1_btb_bm_mod_i   (bm),
    .btb_port_gnt_i    (gnt),
    .btb_rd_en_o       (rd_en),
    .btb_rd_idx_o      (rd_idx),
    .btb_rd_vld_i      (rd_vld),
    .btb_rd_tag_i      (rd_tag),
    .btb_rd_cntr_i     (rd_cntr),
    .btb_wr_en_o       (wr_en),
    .btb_wr_idx_o      (wr_idx),
    .btb_wr_way_o      (wr_way),
    .btb_wr_vld_o      (wr_vld),
    .btb_wr_tag_o      (wr_tag),
    .btb_wr_target_o   (wr_tgt),
    .btb_wr_type_o     (wr_ty),
    .btb_wr_cntr_o     (wr_cntr)
`ifdef BTB_UPD_PERF_EN
    ,
    .perf_upd_cnt_o    (perf_upd),
    .perf_drop_cnt_o   (perf_drop)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: pending record list plus the BTB contents the bench
  // serves as read data; writes from the DUT are applied to it.
  typedef struct {
    int          kind;
    logic [31:0] vpc;
    logic [31:0] tgt;
    logic [1:0]  cp;
    logic [1:0]  ty;
  } rec_t;

  rec_t        mq[$];
  logic        mv[64][2];
  logic [23:0] mt[64][2];
  logic [1:0]  mc[64][2];
  logic        mvic[64];
  bit          outst, cmp_pend, exp_wr;
  logic [5:0]  e_idx;
  logic        e_way, e_vld, e_tog;
  logic [23:0] e_tag;
  logic [31:0] e_tgt;
  logic [1:0]  e_ty, e_cntr;
  int          m_writes, m_drops;

  task automatic predict(input rec_t r);
    int hw;
    int idx;
    logic [1:0] rc;
    idx = int'(r.vpc[7:2]);
    hw = -1;
    for (int w = 0; w < 2; w++)
      if (hw < 0 && mv[idx][w] && mt[idx][w] == r.vpc[31:8]) hw = w;
    rd_vld  = {mv[idx][1], mv[idx][0]};
    rd_tag  = {mt[idx][1], mt[idx][0]};
    rd_cntr = {mc[idx][1], mc[idx][0]};
    e_idx = r.vpc[7:2];
    e_tag = r.vpc[31:8];
    e_tgt = r.tgt;
    e_ty  = r.ty;
    e_tog = 1'b0;
    e_vld = 1'b1;
    rc    = (hw >= 0) ? mc[idx][hw] : 2'b00;
    e_way = (hw == 1);
    exp_wr = (hw >= 0);
    if (r.kind == K_ALLOC) begin
      exp_wr = 1'b1;
      if (hw < 0) begin
        e_way = mvic[idx];
        e_tog = 1'b1;
      end
      if (r.ty == 2'b10)   e_cntr = 2'd3;
      else if (hw >= 0)    e_cntr = (r.cp == 2'd3) ? 2'd3 : r.cp + 2'd1;
      else                 e_cntr = 2'd2;
    end else if (r.kind == K_WEAK) begin
      e_cntr = (rc == 2'd0) ? 2'd0 : rc - 2'd1;
      e_vld  = (rc != 2'd0);
    end else begin
      e_cntr = (rc == 2'd3) ? 2'd3 : rc + 2'd1;
    end
  endtask

  always @(negedge clk) begin
    int   occ;
    bit   pop;
    bit   cmp_now;
    rec_t r;
    if (rst) begin
      mq.delete();
      outst = 0; cmp_pend = 0; exp_wr = 0;
      m_writes = 0; m_drops = 0;
      for (int s = 0; s < 64; s++) mvic[s] = 1'b0;
    end else begin
      occ = mq.size() + (outst ? 1 : 0);
      pop = 0;
      cmp_now = cmp_pend;
      cmp_pend = 0;
      chk("rd_wr_exclusive", {63'd0, rd_en && wr_en}, 64'd0);
      if (wr_en) begin
        chk("wr_expected", {63'd0, exp_wr && !cmp_now}, 64'd1);
        if (gnt && exp_wr && !cmp_now) begin
          chk("wr_idx", wr_idx, e_idx);
          chk("wr_way", wr_way, e_way);
          chk("wr_vld", wr_vld, e_vld);
          chk("wr_tag", wr_tag, e_tag);
          chk("wr_target", wr_tgt, e_tgt);
          chk("wr_type", wr_ty, e_ty);
          chk("wr_cntr", wr_cntr, e_cntr);
          mv[e_idx][e_way] = e_vld;
          mt[e_idx][e_way] = e_tag;
          mc[e_idx][e_way] = e_cntr;
          if (e_tog) mvic[e_idx] = ~mvic[e_idx];
          m_writes++;
          exp_wr = 0; outst = 0; pop = 1;
        end
      end
      if (cmp_now && !exp_wr) begin
        outst = 0; pop = 1;
      end
      if (rd_en) begin
        chk("rd_pending", {63'd0, mq.size() > 0 && !outst}, 64'd1);
        if (mq.size() > 0 && !outst) begin
          chk("rd_idx", rd_idx, mq[0].vpc[7:2]);
          if (gnt) begin
            r = mq.pop_front();
            predict(r);
            outst = 1;
            cmp_pend = 1;
          end
        end
      end
      if (excp || bm) begin
        if (occ < DEPTH || pop) begin
          r.kind = excp ? (present ? K_ALLOC : K_WEAK) : K_REIN;
          r.vpc = vpc; r.tgt = tgt; r.cp = cp; r.ty = ty;
          mq.push_back(r);
        end else m_drops++;
      end
    end
  end

  task automatic enq(input logic e, input logic b, input logic p, input logic [31:0] pc,
                     input logic [31:0] t, input logic [1:0] c, input logic [1:0] y);
    excp = e; bm = b; present = p; vpc = pc; tgt = t; cp = c; ty = y; tkn = b | p;
    @(posedge clk); #1;
    excp = 1'b0; bm = 1'b0;
  endtask

  task automatic wait_wr(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (wr_en) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk({name, "_wr_seen"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_rd(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (rd_en) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk({name, "_rd_seen"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (mq.size() == 0 && !outst && !rd_en && !wr_en) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk({name, "_drain"}, {63'd0, ok}, 64'd1);
  endtask

  task automatic set_entry(input int idx, input int way, input logic v,
                           input logic [23:0] tg, input logic [1:0] c);
    mv[idx][way] = v; mt[idx][way] = tg; mc[idx][way] = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, wc, w0, d0;
    logic [5:0] idx0;
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 2; w++) set_entry(s, w, 1'b0, 24'h0, 2'b00);
    rst = 1'b1; excp = 0; bm = 0; present = 0; tkn = 0; gnt = 1'b1;
    vpc = '0; tgt = '0; cp = '0; ty = '0;
    rd_vld = '0; rd_tag = '0; rd_cntr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", rd_en, 0);
    chk("rst_rd_idx", rd_idx, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_cntr", wr_cntr, 0);
`ifdef BTB_UPD_PERF_EN
    chk("rst_perf_upd", perf_upd, 0);
    chk("rst_perf_drop", perf_drop, 0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    // Allocation miss into an empty set, minimum latency.
    enq(1, 0, 1, 32'h0000_1040, 32'h0000_8000, 2'b01, 2'b00);
    t0 = cyc;
    wait_wr("alloc1");
    chk("alloc1_latency", cyc - t0, 3);
    chk("alloc1_idx", wr_idx, 6'h10);
    chk("alloc1_way", wr_way, 0);
    chk("alloc1_vld", wr_vld, 1);
    chk("alloc1_cntr", wr_cntr, 2'b10);
    chk("alloc1_tag", wr_tag, 24'h000010);
    drain("alloc1");

    // Second miss in the same set goes to the other way.
    enq(1, 0, 1, 32'h0000_2040, 32'h0000_9000, 2'b00, 2'b00);
    wait_wr("alloc2");
    chk("alloc2_idx", wr_idx, 6'h10);
    chk("alloc2_way", wr_way, 1);
    chk("alloc2_cntr", wr_cntr, 2'b10);
    drain("alloc2");

    // Reinforce hits: saturate at 3, and 1 -> 2.
    set_entry(0, 1, 1'b1, 24'h000030, 2'b11);
    enq(0, 1, 0, 32'h0000_3000, 32'h0000_A000, 2'b00, 2'b00);
    wait_wr("rein_sat");
    chk("rein_sat_way", wr_way, 1);
    chk("rein_sat_cntr", wr_cntr, 2'b11);
    chk("rein_sat_vld", wr_vld, 1);
    drain("rein_sat");
    set_entry(0, 1, 1'b1, 24'h000030, 2'b01);
    enq(0, 1, 0, 32'h0000_3000, 32'h0000_A000, 2'b00, 2'b00);
    wait_wr("rein_inc");
    chk("rein_inc_cntr", wr_cntr, 2'b10);
    drain("rein_inc");

    // Weaken hit with counter 0 invalidates; weaken miss writes nothing.
    set_entry(1, 0, 1'b1, 24'h000040, 2'b00);
    enq(1, 0, 0, 32'h0000_4004, 32'h0000_B000, 2'b00, 2'b00);
    wait_wr("weak_hit");
    chk("weak_hit_vld", wr_vld, 0);
    chk("weak_hit_way", wr_way, 0);
    drain("weak_hit");
    wc = 0;
    enq(1, 0, 0, 32'h0000_5008, 32'h0000_C000, 2'b00, 2'b00);
    for (int i = 0; i < 10; i++) begin
      if (wr_en) wc++;
      @(posedge clk); #1;
    end
    chk("weak_miss_no_wr", wc, 0);
    drain("weak_miss");

    // Both sources high: mispredict record wins; jump allocates with 3.
    enq(1, 1, 1, 32'h0000_1040, 32'h0000_D000, 2'b01, 2'b10);
    wait_wr("jump_hit");
    chk("jump_hit_way", wr_way, 0);
    chk("jump_hit_cntr", wr_cntr, 2'b11);
    chk("jump_hit_type", wr_ty, 2'b10);
    drain("jump_hit");
    enq(1, 0, 1, 32'h0000_2040, 32'h0000_E000, 2'b11, 2'b00);
    wait_wr("cond_hit");
    chk("cond_hit_way", wr_way, 1);
    chk("cond_hit_cntr", wr_cntr, 2'b11);
    drain("cond_hit");
    enq(1, 0, 1, 32'h0000_2040, 32'h0000_E000, 2'b00, 2'b00);
    drain("cond_hit2");

    // Five back-to-back records with grant low: fifth is dropped.
    gnt = 1'b0;
    d0 = m_drops;
    for (int i = 0; i < 5; i++)
      enq(1, 0, 1, 32'h0001_0020 + 32'(i * 4), 32'h0002_0000 + 32'(i), 2'b00, 2'b00);
    chk("full_drop_model", m_drops - d0, 1);
`ifdef BTB_UPD_PERF_EN
    chk("full_perf_drop", perf_drop, 1);
`endif
    idx0 = rd_idx;
    chk("stall_rd_idx", idx0, 6'h08);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_rd_en", rd_en, 1);
      chk("stall_rd_idx_stable", rd_idx, idx0);
    end
    w0 = m_writes;
    gnt = 1'b1;
    drain("full");
    chk("full_writes", m_writes - w0, 4);

    // Full queue: enqueue in the same cycle as the head retires is kept.
    w0 = m_writes;
    d0 = m_drops;
    enq(1, 0, 1, 32'h0003_0080, 32'h0003_0000, 2'b00, 2'b00);
    wait_wr("fullpop");
    gnt = 1'b0;
    for (int i = 1; i < 4; i++)
      enq(1, 0, 1, 32'h0003_0080 + 32'(i * 4), 32'h0003_0000 + 32'(i), 2'b00, 2'b00);
    gnt = 1'b1;
    enq(1, 0, 1, 32'h0003_0090, 32'h0003_0004, 2'b00, 2'b00);
    drain("fullpop");
    chk("fullpop_writes", m_writes - w0, 5);
    chk("fullpop_no_drop", m_drops - d0, 0);
`ifdef BTB_UPD_PERF_EN
    chk("perf_upd", perf_upd, m_writes);
    chk("perf_drop", perf_drop, m_drops);
`endif

    // Reset during CMP abandons the record.
    enq(1, 0, 1, 32'h0004_0100, 32'h0004_0000, 2'b00, 2'b00);
    wait_rd("rstcmp");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rstcmp_rd_en", rd_en, 0);
    chk("rstcmp_wr_en", wr_en, 0);
    wc = 0;
    for (int i = 0; i < 6; i++) begin
      if (wr_en || rd_en) wc++;
      @(posedge clk); #1;
    end
    chk("rstcmp_idle", wc, 0);
`ifdef BTB_UPD_PERF_EN
    chk("rstcmp_perf_upd", perf_upd, 0);
`endif

    // Normal operation resumes after reset.
    enq(1, 0, 1, 32'h0000_3040, 32'h0000_F000, 2'b00, 2'b00);
    wait_wr("post_rst");
    chk("post_rst_way", wr_way, 0);
    drain("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
